// File: rtl/trp_burst_seq_pkg.sv
// Shared definitions for the trapezoid burst sequencer: command layout,
// FSM state encoding and default timing limits used by the generator bench too.
package trp_burst_seq_pkg;

  localparam int TRP_TMO_DEF     = 255;
  localparam int TRP_ARM_CLK_DEF = 3;
  localparam int CMD_W           = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4,
    ST_GAP   = 3'd5,
    ST_DRAIN = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic [5:0] m;
    logic       s;
    logic [3:0] rep;
    logic [7:0] gap;
  } burst_cmd_t;

  // A repetition count of zero still means one trapezoid.
  function automatic logic [3:0] rep_norm(input logic [3:0] rep);
    return (rep == 4'd0) ? 4'd1 : rep;
  endfunction

endpackage

// File: rtl/trp_burst_seq_cmd_fifo.sv
// Command queue: DEPTH entries, synchronous push/pop, flush empties it at once.
module trp_cmd_fifo
  import trp_burst_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trp_burst_seq.sv
// Burst sequencer for the trapezoid generator: pops queued commands, issues st
// pulses, holds M/S per trapezoid, spaces pulses in ce ticks and watches T_TRP.
module trp_burst_seq
  import trp_burst_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TMO     = TRP_TMO_DEF,
  parameter int ARM_CLK = TRP_ARM_CLK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_m,
  input  logic       cmd_s,
  input  logic [3:0] cmd_rep,
  input  logic [7:0] cmd_gap,
  input  logic       abort,
  input  logic       err_clr,
  input  logic       ce,
  input  logic       T_TRP,
  output logic       st,
  output logic [5:0] M,
  output logic       S,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] TMO_L = 8'(TMO);
  localparam logic [1:0] ARM_L = 2'(ARM_CLK - 1);

  seq_state_t state;
  burst_cmd_t head;
  logic       full, empty, push, pop;
  logic       arm_fail, wd_fail;
  logic [3:0] rep_left;
  logic [7:0] gap, gap_cnt, wd_cnt;
  logic [1:0] arm_cnt;

  // Command handshake: a command transfers on a clock where cmd_valid and
  // cmd_ready are both high; a push in the same cycle as abort is discarded.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !abort;
  assign pop       = (state == ST_LOAD) && !abort;
  assign busy      = (state != ST_IDLE) || !empty;

  assign arm_fail = (state == ST_ARM) && !abort && !T_TRP && (arm_cnt == ARM_L);
  assign wd_fail  = (state == ST_RUN) && !abort && T_TRP && (wd_cnt == TMO_L);

  trp_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_m, cmd_s, cmd_rep, cmd_gap}),
    .pop   (pop),
    .flush (abort),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      st       <= 1'b0;
      M        <= '0;
      S        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rep_left <= '0;
      gap      <= '0;
      gap_cnt  <= '0;
      wd_cnt   <= '0;
      arm_cnt  <= '0;
    end else begin
      st   <= 1'b0;
      done <= 1'b0;
      if (arm_fail || wd_fail) err <= 1'b1;
      else if (err_clr)        err <= 1'b0;
      if (abort) rep_left <= 4'd1;

      case (state)
        // Never start while the generator still reports busy.
        ST_IDLE: if (!empty && !abort && !err && !T_TRP) state <= ST_LOAD;
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            M        <= head.m;
            S        <= head.s;
            rep_left <= rep_norm(head.rep);
            gap      <= head.gap;
            st       <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          arm_cnt <= '0;
          state   <= abort ? ST_IDLE : ST_ARM;
        end
        ST_ARM: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (T_TRP) begin
            wd_cnt <= '0;
            state  <= ST_RUN;
          end else if (arm_fail) begin
            state <= ST_DRAIN;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (!T_TRP) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else if (wd_fail) begin
            state <= ST_DRAIN;
          end else if (ce && wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (gap_cnt == gap) begin
            if (rep_left > 4'd1) begin
              rep_left <= rep_left - 1'b1;
              st       <= 1'b1;
              state    <= ST_START;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end else if (ce) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_DRAIN: if (!T_TRP) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/trp_burst_seq.md
Name: trp_burst_seq

Overview:
Sequencer for the trapezoidal modulation-code generator (MTRP generator: st, M, S in; T_TRP, ce out). It accepts queued burst commands (amplitude, sign, repetition count, inter-pulse gap) and issues one-clock st pulses. It holds M/S stable for each whole trapezoid and enforces gaps counted in ce ticks. A watchdog flags a generator that never finishes. It sits between the lab control logic / UART command decoder and the generator.

Parameters:
DEPTH, 4, command FIFO depth (power of 2, ≥2)
TMO, 255, max ce ticks T_TRP may stay high before error
ARM_CLK, 3, max clk cycles from st to T_TRP=1 before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_m  in  6  amplitude M for generator
cmd_s  in  1  sign S for generator
cmd_rep  in  4  trapezoids in burst (0 treated as 1)
cmd_gap  in  8  ce ticks between trapezoids/commands
abort  in  1  flush queue, stop after current trapezoid
err_clr  in  1  clears err
ce  in  1  generator clock-enable tick
T_TRP  in  1  generator busy flag
st  out  1  start pulse to generator
M  out  6  amplitude to generator
S  out  1  sign to generator
busy  out  1  FSM not IDLE or FIFO non-empty
done  out  1  one-clk pulse when a command's last trapezoid+gap completes
err  out  1  sticky watchdog/arming error

Behaviour:
- Reset: st=0, M=0, S=0, done=0, err=0, busy=0, FIFO empty (cmd_ready=1), FSM=IDLE, counters 0.
- Push on cmd_valid&cmd_ready. When full, cmd_ready=0 regardless of same-cycle pop (no push-through).
- FSM states: IDLE, LOAD, START, ARM, RUN, GAP, DRAIN.
- IDLE: FIFO non-empty & !abort -> LOAD.
- LOAD (1 clk): pop head into rep_left (0->1), gap, M, S registers -> START. M/S change only in LOAD.
- START (1 clk): st=1 -> ARM; clear arm counter.
- ARM: T_TRP=1 -> RUN, clear wd counter. If still 0 after ARM_CLK clks: err=1 -> DRAIN.
- RUN: wd counter increments on ce while T_TRP=1. T_TRP=0 -> GAP, clear gap counter. If wd reaches TMO with T_TRP still 1: err=1 -> DRAIN.
- GAP: gap counter increments on ce. Exit when counter==gap (gap=0 exits the cycle after entry). Then:
  - rep_left>1: decrement -> START (same M/S).
  - Otherwise: done=1 for one clk -> IDLE (next command loads 2 clks later).
- abort (any clk, level): FIFO flushed same cycle; rep_left forced to 1.
  - In IDLE/LOAD/START: -> IDLE; st is suppressed if not yet issued.
  - In ARM/RUN: -> DRAIN.
  - In GAP: -> IDLE.
  - No done pulse for an aborted command. A push coinciding with abort is dropped.
- DRAIN: wait T_TRP=0 (no timeout) -> IDLE; no st issued.
- err: set by watchdog/arming failure; cleared by err_clr (set wins if same cycle). Queue stays paused while err=1.
- st is exactly one clk wide, never asserted while T_TRP=1.
- Counters: wd 8 bits, saturating. Gap counter 8 bits. Arm counter 2 bits.

Decomposition:
- Generator timing constants (Fclk, BR, NP, NRF) remain in shared CONST.v.
- Add TRP_TMO_DEF and FSM state encodings there so the generator bench and this block agree.
- One sub-module: trp_cmd_fifo (DEPTH x 19-bit synchronous FIFO with full/empty and flush).

Test Plan:
Bench: ce every 4 clks; generator model raises T_TRP 1 clk after st and holds it 20 ce ticks.
1. Single cmd M=5,S=1,rep=1,gap=0 -> exactly one st pulse; M=5/S=1 held for the full trapezoid; done 1 clk after T_TRP falls plus GAP exit; busy then 0.
2. cmd rep=3,gap=10 -> 3 st pulses, each rising edge of T_TRP ≥10 ce ticks after the previous fall; single done.
3. Push 5 cmds back-to-back with DEPTH=4 -> cmd_ready=0 after 4th; 5th accepted once first LOAD pops; 5 done pulses in order; M values follow command order.
4. abort mid-RUN with 2 queued -> no further st; FSM waits in DRAIN until T_TRP=0; IDLE; no done; cmd_ready=1, FIFO empty.
5. Model holds T_TRP high 300 ce ticks -> err=1 at 255 ticks; DRAIN; no new st until err_clr; queue resumes after.
6. Model never raises T_TRP -> err=1 three clks after st. Then assert rst_n=0 mid-burst -> all outputs return to reset values immediately (asynchronous).
